// File: rtl/day01_pkg.sv
// Shared definitions for the day01 parser and rotator.
// ASCII codes, parser state encoding and direction values.
package day01_pkg;

    localparam int STEP_W_DEF = 32;

    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_NL = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NUM  = 2'd1,
        SKIP = 2'd2,
        EMIT = 2'd3
    } state_e;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/day01_dec_acc.sv
// Decimal accumulate step: acc_next = acc*10 + digit.
// Ports: acc, digit in; acc_next, ovf (result exceeds STEP_W bits) out.
module day01_dec_acc
    import day01_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic [STEP_W-1:0] acc,
    input  logic [3:0]        digit,
    output logic [STEP_W-1:0] acc_next,
    output logic              ovf
);

    // acc*10+9 < 16*2^STEP_W, so four extra bits never lose a carry.
    logic [STEP_W+3:0] wide;

    always_comb begin
        wide = ({4'b0, acc} << 3)
             + ({4'b0, acc} << 1)
             + {{STEP_W{1'b0}}, digit};
        acc_next = wide[STEP_W-1:0];
        ovf      = |wide[STEP_W+3:STEP_W];
    end

endmodule

// File: rtl/day01_line_parser.sv
// ASCII line parser: "L68\n" / "R5\n" -> (dir, steps) commands.
// Ports: byte stream in (valid/ready/last), command out (valid/ready), debug counters, busy.
module day01_line_parser
    import day01_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic              out_dir,
    output logic [STEP_W-1:0] out_steps,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  line_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [STEP_W-1:0] acc_q, acc_d;
    logic              seen_q, seen_d;
    logic              dir_q, dir_d;
    logic              out_valid_q, out_valid_d;
    logic [STEP_W-1:0] out_steps_q, out_steps_d;
    logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic [STEP_W-1:0] acc_nxt;
    logic              acc_ovf;
    logic              err_inc;
    logic              is_ws;

    // For '0'..'9' the low nibble is the digit value.
    day01_dec_acc #(.STEP_W(STEP_W)) u_dec_acc (
        .acc      (acc_q),
        .digit    (in_data[3:0]),
        .acc_next (acc_nxt),
        .ovf      (acc_ovf)
    );

    assign in_ready   = (state_q != EMIT);
    assign out_valid  = out_valid_q;
    assign out_dir    = dir_q;
    assign out_steps  = out_steps_q;
    assign line_count = line_cnt_q;
    assign err_count  = err_cnt_q;
    assign busy       = (state_q != IDLE) || out_valid_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        seen_d      = seen_q;
        dir_d       = dir_q;
        out_valid_d = out_valid_q;
        out_steps_d = out_steps_q;
        line_cnt_d  = line_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_inc     = 1'b0;
        is_ws       = (in_data == CH_NL) || (in_data == CH_CR)
                   || (in_data == CH_SP);

        if (state_q == EMIT) begin
            if (out_ready) begin
                out_valid_d = 1'b0;
                line_cnt_d  = line_cnt_q + CNT_W'(1);
                state_d     = IDLE;
            end
        end else if (in_valid) begin
            case (state_q)
                IDLE: begin
                    if ((in_data == CH_L) || (in_data == CH_R)) begin
                        dir_d   = (in_data == CH_R) ? DIR_RIGHT : DIR_LEFT;
                        acc_d   = '0;
                        seen_d  = 1'b0;
                        state_d = NUM;
                    end else if (!is_ws) begin
                        state_d = SKIP;
                    end
                end
                NUM: begin
                    if (is_digit(in_data)) begin
                        if (acc_ovf) begin
                            state_d = SKIP;
                        end else begin
                            acc_d  = acc_nxt;
                            seen_d = 1'b1;
                        end
                    end else if (in_data == CH_NL) begin
                        if (seen_q) begin
                            state_d = EMIT;
                        end else begin
                            err_inc = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (in_data != CH_CR) begin
                        state_d = SKIP;
                    end
                end
                SKIP: begin
                    if (in_data == CH_NL) begin
                        err_inc = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase

            // in_last closes the line after the byte's own effect.
            if (in_last) begin
                case (state_d)
                    NUM: begin
                        if (seen_d) begin
                            state_d = EMIT;
                        end else begin
                            err_inc = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    SKIP: begin
                        err_inc = 1'b1;
                        state_d = IDLE;
                    end
                    default: ;
                endcase
            end

            if (state_d == EMIT) begin
                out_valid_d = 1'b1;
                out_steps_d = acc_d;
            end
            if (err_inc) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            seen_q      <= 1'b0;
            dir_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_steps_q <= '0;
            line_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            seen_q      <= seen_d;
            dir_q       <= dir_d;
            out_valid_q <= out_valid_d;
            out_steps_q <= out_steps_d;
            line_cnt_q  <= line_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule
